// File: rtl/mdu.sv
//==============================================================================
// Module   : mdu
// Purpose  : Multi-cycle multiply/divide unit with architectural HI/LO.
//            Optional MADD/MADDU/MSUB/MSUBU enabled by macro MDU_MADD_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mdu #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] result,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] c_op_mult  = 4'd1;
    localparam logic [3:0] c_op_multu = 4'd2;
    localparam logic [3:0] c_op_div   = 4'd3;
    localparam logic [3:0] c_op_divu  = 4'd4;
    localparam logic [3:0] c_op_mfhi  = 4'd5;
    localparam logic [3:0] c_op_mflo  = 4'd6;
    localparam logic [3:0] c_op_mthi  = 4'd7;
    localparam logic [3:0] c_op_mtlo  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] c_op_madd  = 4'd9;
    localparam logic [3:0] c_op_maddu = 4'd10;
    localparam logic [3:0] c_op_msub  = 4'd11;
    localparam logic [3:0] c_op_msubu = 4'd12;
`endif

    localparam logic [3:0] c_mul_cnt = 4'(MUL_CYCLES);
    localparam logic [3:0] c_div_cnt = 4'(DIV_CYCLES);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_busy;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;
    logic        r_pend_wr;

    // Products: low 64 bits of the sign-extended product equal the signed product
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    assign w_prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign w_prod_u = {32'd0, a} * {32'd0, b};

    // Signed division done on magnitudes; INT_MIN / -1 falls out as 0x80000000 r 0
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_den_s;
    logic [31:0] w_den_u;
    logic [31:0] w_mag_q;
    logic [31:0] w_mag_r;
    logic [31:0] w_quo_s;
    logic [31:0] w_rem_s;
    logic [31:0] w_quo_u;
    logic [31:0] w_rem_u;
    logic        w_b_zero;

    assign w_b_zero = (b == 32'd0);
    assign w_abs_a  = a[31] ? (32'd0 - a) : a;
    assign w_abs_b  = b[31] ? (32'd0 - b) : b;
    assign w_den_s  = w_b_zero ? 32'd1 : w_abs_b;
    assign w_den_u  = w_b_zero ? 32'd1 : b;
    assign w_mag_q  = w_abs_a / w_den_s;
    assign w_mag_r  = w_abs_a % w_den_s;
    assign w_quo_s  = (a[31] ^ b[31]) ? (32'd0 - w_mag_q) : w_mag_q;
    assign w_rem_s  = a[31] ? (32'd0 - w_mag_r) : w_mag_r;
    assign w_quo_u  = a / w_den_u;
    assign w_rem_u  = a % w_den_u;

    logic        w_launch;
    logic [3:0]  w_cycles;
    logic [63:0] w_new;
    logic        w_new_wr;

    always_comb begin
        w_launch = 1'b0;
        w_cycles = 4'd0;
        w_new    = 64'd0;
        w_new_wr = 1'b0;
        case (op)
            c_op_mult:  begin w_launch = 1'b1; w_cycles = c_mul_cnt; w_new = w_prod_s; w_new_wr = 1'b1; end
            c_op_multu: begin w_launch = 1'b1; w_cycles = c_mul_cnt; w_new = w_prod_u; w_new_wr = 1'b1; end
            c_op_div:   begin w_launch = 1'b1; w_cycles = c_div_cnt; w_new = {w_rem_s, w_quo_s}; w_new_wr = !w_b_zero; end
            c_op_divu:  begin w_launch = 1'b1; w_cycles = c_div_cnt; w_new = {w_rem_u, w_quo_u}; w_new_wr = !w_b_zero; end
`ifdef MDU_MADD_EN
            c_op_madd:  begin w_launch = 1'b1; w_cycles = c_mul_cnt; w_new = {r_hi, r_lo} + w_prod_s; w_new_wr = 1'b1; end
            c_op_maddu: begin w_launch = 1'b1; w_cycles = c_mul_cnt; w_new = {r_hi, r_lo} + w_prod_u; w_new_wr = 1'b1; end
            c_op_msub:  begin w_launch = 1'b1; w_cycles = c_mul_cnt; w_new = {r_hi, r_lo} - w_prod_s; w_new_wr = 1'b1; end
            c_op_msubu: begin w_launch = 1'b1; w_cycles = c_mul_cnt; w_new = {r_hi, r_lo} - w_prod_u; w_new_wr = 1'b1; end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_busy    <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_wr <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_launch) begin
                            r_pend_hi <= w_new[63:32];
                            r_pend_lo <= w_new[31:0];
                            r_pend_wr <= w_new_wr;
                            r_cnt     <= w_cycles;
                            r_busy    <= 1'b1;
                            r_state   <= S_BUSY;
                        end else if (op == c_op_mthi) begin
                            r_hi <= a;
                        end else if (op == c_op_mtlo) begin
                            r_lo <= a;
                        end
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt - 4'd1;
                    // Last busy cycle: commit and free the unit on the same edge
                    if (r_cnt == 4'd1) begin
                        if (r_pend_wr) begin
                            r_hi <= r_pend_hi;
                            r_lo <= r_pend_lo;
                        end
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy   = r_busy;
    assign hi     = r_hi;
    assign lo     = r_lo;
    assign result = (op == c_op_mfhi) ? r_hi :
                    (op == c_op_mflo) ? r_lo : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_mdu.sv
//==============================================================================
// Module   : tb_mdu
// Purpose  : Table-driven, scoreboard-checked bench for mdu.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mdu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic [31:0] result;
    logic [31:0] hi;
    logic [31:0] lo;

    mdu #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .result (result),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    vec_t tv[14];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Entered at the k-th negedge after the accepting edge with n0 = k-1
    task automatic wait_done(input string nm, input int n0);
        int   n;
        exp_t e;
        n = n0;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            e = sb.pop_front();
            check({nm, "_cycles"}, 32'(n), 32'(e.cyc));
            check({nm, "_hi"}, hi, e.hi);
            check({nm, "_lo"}, lo, e.lo);
        end
    endtask

    task automatic drive(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] ehi, input logic [31:0] elo, input int ecyc);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        sb.push_back('{ehi, elo, ecyc});
    endtask

    task automatic issue(input string nm, input logic [3:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] ehi,
                         input logic [31:0] elo, input int ecyc);
        @(negedge clk);
        drive(o, x, y, ehi, elo, ecyc);
        @(negedge clk);
        start = 1'b0;
        op    = 4'd0;
        a     = 32'd0;
        b     = 32'd0;
        wait_done(nm, 0);
    endtask

    initial begin
        tv[0]  = '{4'd1,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        tv[1]  = '{4'd2,  32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 5};
        tv[2]  = '{4'd3,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        tv[3]  = '{4'd4,  32'd7,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        tv[4]  = '{4'd3,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        tv[5]  = '{4'd4,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10};
        tv[6]  = '{4'd3,  32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        tv[7]  = '{4'd1,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
        tv[8]  = '{4'd7,  32'h12345678, 32'd0,        32'h12345678, 32'h00000000, 0};
        tv[9]  = '{4'd8,  32'hCAFEF00D, 32'd0,        32'h12345678, 32'hCAFEF00D, 0};
        tv[10] = '{4'd0,  32'h11111111, 32'd5,        32'h12345678, 32'hCAFEF00D, 0};
        tv[11] = '{4'd15, 32'h22222222, 32'd5,        32'h12345678, 32'hCAFEF00D, 0};
        tv[12] = '{4'd2,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        tv[13] = '{4'd5,  32'h33333333, 32'd9,        32'hFFFFFFFE, 32'h00000001, 0};

        // Reset state
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_result", result, 32'd0);

        for (int i = 0; i < 14; i++)
            issue($sformatf("vec%0d", i), tv[i].op, tv[i].a, tv[i].b, tv[i].hi, tv[i].lo, tv[i].cyc);

        // Combinational read port
        op = 4'd5; #1;
        check("mfhi_result", result, 32'hFFFFFFFE);
        op = 4'd6; #1;
        check("mflo_result", result, 32'h00000001);
        op = 4'd1; #1;
        check("other_result", result, 32'd0);
        op = 4'd0;

        // MTHI while busy is ignored, then accepted once idle
        @(negedge clk);
        drive(4'd1, 32'd2, 32'd3, 32'd0, 32'd6, 5);
        @(negedge clk);
        sb.push_back('{32'd0, 32'd0, 0});
        void'(sb.pop_back());
        start = 1'b1; op = 4'd7; a = 32'h12345678; b = 32'd0;
        @(negedge clk);
        start = 1'b0; op = 4'd0; a = 32'd0;
        wait_done("mthi_busy", 1);
        issue("mthi_idle", 4'd7, 32'h12345678, 32'd0, 32'h12345678, 32'd6, 0);
        op = 4'd5; #1;
        check("mfhi_after_mthi", result, 32'h12345678);
        op = 4'd0;

        // Back-to-back accept on the cycle busy first reads 0
        @(negedge clk);
        drive(4'd2, 32'd3, 32'd3, 32'd0, 32'd9, 5);
        @(negedge clk);
        start = 1'b0; op = 4'd0;
        wait_done("b2b_first", 0);
        drive(4'd2, 32'd4, 32'd4, 32'd0, 32'd16, 5);
        @(negedge clk);
        start = 1'b0; op = 4'd0;
        wait_done("b2b_second", 0);

        // Reset aborts an in-flight multiply
        @(negedge clk);
        start = 1'b1; op = 4'd1; a = 32'hFFFFFFFE; b = 32'd3;
        @(negedge clk);
        start = 1'b0; op = 4'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        repeat (8) @(negedge clk);
        check("abort_late_hi", hi, 32'd0);
        check("abort_late_lo", lo, 32'd0);

        // Reset wins over start on the same edge
        reset = 1'b1; start = 1'b1; op = 4'd7; a = 32'hAAAA5555;
        @(negedge clk);
        reset = 1'b0; start = 1'b0; op = 4'd0;
        @(negedge clk);
        check("rst_prio_hi", hi, 32'd0);
        check("rst_prio_busy", 32'(busy), 32'd0);

        // Multiply-accumulate class
        issue("mtlo_ones", 4'd8, 32'hFFFFFFFF, 32'd0, 32'd0, 32'hFFFFFFFF, 0);
`ifdef MDU_MADD_EN
        issue("maddu", 4'd10, 32'd1, 32'd1, 32'd1, 32'd0, 5);
        issue("msub", 4'd11, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF, 5);
`else
        issue("maddu", 4'd10, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF, 0);
        issue("msub", 4'd11, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
